// File: rtl/pipe_pkg.sv
// Shared pipeline widths and the control-field layouts carried between stages.
package pipe_pkg;

  localparam int IFID_DATA_W  = 64;  // pc + instruction word
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 96;  // pc + rs1/rs2 operands or imm + rd
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 72;  // alu result + store data + rd
  localparam int EXMEM_CTRL_W = 8;

  typedef struct packed {
    logic       reg_we;
    logic       ram_we;
    logic       ram_re;
    logic       stdio_we;
    logic       stdio_re;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic       branch;
  } idex_ctrl_t;

  typedef struct packed {
    logic       reg_we;
    logic       ram_we;
    logic       ram_re;
    logic       stdio_we;
    logic       stdio_re;
    logic [1:0] wb_sel;
    logic       sign_ext;
  } exmem_ctrl_t;

  // Forward the memory/writeback controls once execute has consumed the rest.
  function automatic exmem_ctrl_t idex_to_exmem(input idex_ctrl_t c);
    exmem_ctrl_t r;
    r.reg_we   = c.reg_we;
    r.ram_we   = c.ram_we;
    r.ram_re   = c.ram_re;
    r.stdio_we = c.stdio_we;
    r.stdio_re = c.stdio_re;
    r.wb_sel   = c.wb_sel;
    r.sign_ext = c.alu_op[3];
    return r;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + data + ctrl, with load, clear and ctrl masking.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Load beats clear; an emptied slot also drops its ctrl so bubbles carry no strobes.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d_data;
      ctrl_d  = d_ctrl;
    end else if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign ctrl  = valid_q ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush, bubble masking and optional skid slot.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  logic              in_fire, out_fire;
  logic              main_load, main_clr;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CNT_W-1:0]  stall_q, stall_d;

  // SKID=1 breaks the out_ready -> in_ready path: ready only depends on skid state.
  assign in_ready = (SKID == 0) ? (!out_valid || out_ready) : !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Main slot refills from skid first (FIFO order), else from upstream when free or draining.
  always_comb begin
    main_load   = 1'b0;
    main_clr    = flush || out_fire;
    main_d_data = in_data;
    main_d_ctrl = in_ctrl;
    if (!flush) begin
      if (out_fire && skid_valid) begin
        main_load   = 1'b1;
        main_d_data = skid_data;
        main_d_ctrl = skid_ctrl;
      end else if (in_fire && (!out_valid || out_fire)) begin
        main_load = 1'b1;
      end
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clr    (main_clr),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (out_valid),
    .data   (out_data),
    .ctrl   (out_ctrl)
  );

  generate
    if (SKID == 0) begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end else begin : g_skid
      logic skid_load, skid_clr;
      // Skid catches an accepted entry while main is held; it empties by moving into main.
      assign skid_load = !flush && in_fire && out_valid && !out_fire;
      assign skid_clr  = flush || out_fire;
      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clr    (skid_clr),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );
    end
  endgenerate

  // Saturating count of stalled cycles; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
  assign occupancy   = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 instance and one SKID=1 / CNT_W=4 instance,
// checked against a FIFO-of-entries reference model.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk, reset;
  logic          flush [2];
  logic          in_valid [2];
  logic          in_ready [2];
  logic [DW-1:0] in_data [2];
  logic [CW-1:0] in_ctrl [2];
  logic          ov [2];
  logic          out_ready [2];
  logic [DW-1:0] od [2];
  logic [CW-1:0] oc [2];
  logic [1:0]    occ [2];
  logic [15:0]   sc0;
  logic [3:0]    sc1;

  int n_chk = 0;
  int n_fail = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(ov[0]), .out_ready(out_ready[0]), .out_data(od[0]),
    .out_ctrl(oc[0]), .occupancy(occ[0]), .stall_count(sc0));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(ov[1]), .out_ready(out_ready[1]), .out_data(od[1]),
    .out_ctrl(oc[1]), .occupancy(occ[1]), .stall_count(sc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of held entries, capacity 1 or 2.
  typedef struct packed { logic [DW-1:0] d; logic [CW-1:0] c; } ent_t;
  ent_t m [2][2];
  int   mcnt [2] = '{0, 0};
  int   msc [2]  = '{0, 0};
  int   smax [2] = '{65535, 15};

  function automatic bit m_ready(input int k);
    return (k == 0) ? (mcnt[0] == 0 || out_ready[0]) : (mcnt[1] < 2);
  endfunction

  function automatic int scv(input int k);
    return (k == 0) ? int'(sc0) : int'(sc1);
  endfunction

  initial begin : model
    bit rdy;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        rdy = m_ready(k);
        if (reset) begin
          mcnt[k] = 0;
          msc[k]  = 0;
        end else begin
          if (mcnt[k] > 0 && !out_ready[k] && msc[k] < smax[k]) msc[k]++;
          if (flush[k]) mcnt[k] = 0;
          else begin
            if (mcnt[k] > 0 && out_ready[k]) begin
              m[k][0] = m[k][1];
              mcnt[k]--;
            end
            if (in_valid[k] && rdy) begin
              m[k][mcnt[k]] = ent_t'{in_data[k], in_ctrl[k]};
              mcnt[k]++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      flush[k] = 0; in_valid[k] = 0; out_ready[k] = 0;
      in_data[k] = '0; in_ctrl[k] = '0;
    end
  endtask

  task automatic apply_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1; in_data[k] = 32'hDEAD_0000 + k; in_ctrl[k] = 16'hFFFF; out_ready[k] = 0;
    end
    tick();
    tick();
    reset = 0;
    for (int k = 0; k < 2; k++) in_valid[k] = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (ov[k] !== 1'b0 || oc[k] !== '0 || od[k] !== '0 || occ[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset%0d: valid=%b ctrl=%h data=%h occ=%0d, expected 0/0/0/0", k, ov[k], oc[k], od[k], occ[k]);
      end
      n_chk++;
      if (scv(k) !== 0 || in_ready[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_cnt%0d: stall=%0d in_ready=%b, expected 0/1", k, scv(k), in_ready[k]);
      end
    end
  endtask

  task automatic test_stream(input int k);
    apply_reset();
    out_ready[k] = 1;
    in_valid[k] = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data[k] = DW'(i);
      in_ctrl[k] = CW'(i);
      tick();
      n_chk++;
      if (ov[k] !== 1'b1 || od[k] !== DW'(i) || oc[k] !== CW'(i)) begin
        n_fail++;
        $display("FAIL stream%0d beat %0d: valid=%b data=%0d ctrl=%0d, expected 1/%0d/%0d", k, i, ov[k], od[k], oc[k], i, i);
      end
      n_chk++;
      if (occ[k] > 2'd1) begin
        n_fail++;
        $display("FAIL stream_occ%0d: occupancy=%0d, expected <=1", k, occ[k]);
      end
    end
    in_valid[k] = 0;
    tick();
    n_chk++;
    if (ov[k] !== 1'b0 || oc[k] !== '0) begin
      n_fail++;
      $display("FAIL stream_drain%0d: valid=%b ctrl=%h, expected 0/0", k, ov[k], oc[k]);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got [$];
    bit acc;
    apply_reset();
    out_ready[1] = 0;
    in_valid[1] = 1; in_data[1] = 5; in_ctrl[1] = 16'h0005;
    tick();
    in_data[1] = 6; in_ctrl[1] = 16'h0006;
    tick();
    n_chk++;
    if (in_ready[1] !== 1'b0 || occ[1] !== 2'd2 || od[1] !== 32'd5 || sc1 !== 4'd1) begin
      n_fail++;
      $display("FAIL bp_full: in_ready=%b occ=%0d data=%0d stall=%0d, expected 0/2/5/1", in_ready[1], occ[1], od[1], sc1);
    end
    in_data[1] = 7; in_ctrl[1] = 16'h0007;
    repeat (3) tick();
    n_chk++;
    if (in_ready[1] !== 1'b0 || occ[1] !== 2'd2 || od[1] !== 32'd5 || sc1 !== 4'd4) begin
      n_fail++;
      $display("FAIL bp_hold: in_ready=%b occ=%0d data=%0d stall=%0d, expected 0/2/5/4", in_ready[1], occ[1], od[1], sc1);
    end
    out_ready[1] = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ov[1]) got.push_back(od[1]);
      acc = in_valid[1] && in_ready[1];
      tick();
      if (acc) in_valid[1] = 0;
    end
    n_chk++;
    if (got.size() != 3 || got[0] !== 32'd5 || got[1] !== 32'd6 || got[2] !== 32'd7) begin
      n_fail++;
      $display("FAIL bp_order: got %0d entries %p, expected 5,6,7", got.size(), got);
    end
    n_chk++;
    if (sc1 !== 4'd4) begin
      n_fail++;
      $display("FAIL bp_stall_after: stall=%0d, expected 4", sc1);
    end
  endtask

  task automatic test_flush(input int k);
    int cap;
    cap = (k == 0) ? 1 : 2;
    apply_reset();
    out_ready[k] = 0;
    for (int i = 1; i <= cap; i++) begin
      in_valid[k] = 1; in_data[k] = DW'(i); in_ctrl[k] = 16'h00F0;
      tick();
    end
    n_chk++;
    if (occ[k] !== 2'(cap)) begin
      n_fail++;
      $display("FAIL flush_fill%0d: occ=%0d, expected %0d", k, occ[k], cap);
    end
    flush[k] = 1; in_valid[k] = 1; in_data[k] = 9; in_ctrl[k] = 16'hFFFF;
    tick();
    flush[k] = 0; in_valid[k] = 0;
    n_chk++;
    if (ov[k] !== 1'b0 || oc[k] !== '0 || occ[k] !== 2'd0) begin
      n_fail++;
      $display("FAIL flush%0d: valid=%b ctrl=%h occ=%0d, expected 0/0/0", k, ov[k], oc[k], occ[k]);
    end
    out_ready[k] = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++;
      if (ov[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak%0d: valid=%b data=%0d, expected no entry", k, ov[k], od[k]);
      end
    end
  endtask

  task automatic test_bubble(input int k);
    apply_reset();
    in_valid[k] = 0;
    in_ctrl[k] = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      out_ready[k] = 1'($urandom);
      in_data[k] = $urandom;
      tick();
      n_chk++;
      if (ov[k] !== 1'b0 || oc[k] !== '0) begin
        n_fail++;
        $display("FAIL bubble%0d cyc %0d: valid=%b ctrl=%h, expected 0/0", k, c, ov[k], oc[k]);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    out_ready[1] = 0;
    in_valid[1] = 1; in_data[1] = 32'h33; in_ctrl[1] = 16'h1;
    tick();
    in_valid[1] = 0;
    repeat (20) tick();
    n_chk++;
    if (sc1 !== 4'd15) begin
      n_fail++;
      $display("FAIL sat: stall=%0d, expected 15", sc1);
    end
    flush[1] = 1;
    tick();
    flush[1] = 0;
    n_chk++;
    if (sc1 !== 4'd15 || ov[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_flush: stall=%0d valid=%b, expected 15/0", sc1, ov[1]);
    end
    reset = 1;
    tick();
    reset = 0;
    n_chk++;
    if (sc1 !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_reset: stall=%0d, expected 0", sc1);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    out_ready[1] = 0;
    in_valid[1] = 1; in_data[1] = 32'h44; in_ctrl[1] = 16'h2;
    tick();
    in_valid[1] = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    n_chk++;
    if (ov[1] !== 1'b0 || occ[1] !== 2'd0 || oc[1] !== '0) begin
      n_fail++;
      $display("FAIL reset_stall: valid=%b occ=%0d ctrl=%h, expected 0/0/0", ov[1], occ[1], oc[1]);
    end
  endtask

  task automatic test_random(input int k);
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid[k]  = ($urandom % 4) != 0;
      out_ready[k] = ($urandom % 3) != 0;
      flush[k]     = ($urandom % 25) == 0;
      in_data[k]   = $urandom;
      in_ctrl[k]   = CW'($urandom);
      #1;
      n_chk++;
      if (in_ready[k] !== m_ready(k)) begin
        n_fail++;
        $display("FAIL rand%0d in_ready cyc %0d: got %b, expected %b", k, c, in_ready[k], m_ready(k));
      end
      tick();
      n_chk++;
      if (ov[k] !== (mcnt[k] > 0) || occ[k] !== 2'(mcnt[k])) begin
        n_fail++;
        $display("FAIL rand%0d state cyc %0d: valid=%b occ=%0d, expected %0d entries", k, c, ov[k], occ[k], mcnt[k]);
      end
      n_chk++;
      if (mcnt[k] > 0 && (od[k] !== m[k][0].d || oc[k] !== m[k][0].c)) begin
        n_fail++;
        $display("FAIL rand%0d head cyc %0d: data=%h ctrl=%h, expected %h/%h", k, c, od[k], oc[k], m[k][0].d, m[k][0].c);
      end
      n_chk++;
      if (mcnt[k] == 0 && oc[k] !== '0) begin
        n_fail++;
        $display("FAIL rand%0d bubble cyc %0d: ctrl=%h, expected 0", k, c, oc[k]);
      end
      n_chk++;
      if (scv(k) !== msc[k]) begin
        n_fail++;
        $display("FAIL rand%0d stall cyc %0d: got %0d, expected %0d", k, c, scv(k), msc[k]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_stream(0);
    test_stream(1);
    test_backpressure();
    test_flush(0);
    test_flush(1);
    test_bubble(0);
    test_bubble(1);
    test_saturation();
    test_reset_mid_stall();
    test_random(0);
    test_random(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
